dispense_stepper: RTL and testbench

Drives the four-coil stepper that turns the candy dispenser wheel.
- Consumes the slow step-rate clock produced by the clock divider as a sampled data signal, not as a clock. It synchronises that signal into the system clock domain and uses each rising edge as one step tick.
- On a dispense request it advances the motor a fixed number of steps, holds position for a settle period, de-energises the coils and reports completion.

---
 rtl/stepper_pkg.sv | 25 ++
 rtl/edge_sync.sv | 27 ++
 rtl/dispense_stepper.sv | 122 ++++++++++++
 tb/tb_dispense_stepper.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_pkg.sv
// rtl/stepper_pkg.sv - shared state encoding and coil phase tables for the dispenser stepper
package stepper_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      SETTLE = 2'd2,
      DONE   = 2'd3
   } state_e;

   // Bit 3 drives coil A.
   localparam logic [3:0] HALF_TABLE [0:7] = '{
      4'b1000, 4'b1100, 4'b0100, 4'b0110,
      4'b0010, 4'b0011, 4'b0001, 4'b1001
   };

   localparam logic [3:0] FULL_TABLE [0:3] = '{
      4'b1100, 4'b0110, 4'b0011, 4'b1001
   };

   function automatic int unsigned phase_len(input bit half_step);
      return half_step ? 8 : 4;
   endfunction

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - two-flop synchroniser with a one-cycle rising-edge pulse
module edge_sync (
   input  logic clk_in,
   input  logic rst_n,
   input  logic async_in,
   output logic rise_pulse
);

   logic sync1_q;
   logic sync2_q;
   logic sync3_q;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
      end else begin
         sync1_q <= async_in;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   assign rise_pulse = sync2_q & ~sync3_q;

endmodule

// File: rtl/dispense_stepper.sv
// rtl/dispense_stepper.sv - steps the dispenser wheel a fixed count per request, settles, then reports done
module dispense_stepper
   import stepper_pkg::*;
#(
   parameter int STEPS_PER_DISPENSE = 512,
   parameter int SETTLE_TICKS       = 8,
   parameter bit HALF_STEP          = 1'b1
) (
   input  logic       clk_in,
   input  logic       rst_n,
   input  logic       step_clk_in,
   input  logic       dispense_req,
   input  logic       dir,
   input  logic       abort,
   output logic       busy,
   output logic       done,
   output logic [3:0] coil
);

   localparam int STEP_W = $clog2(STEPS_PER_DISPENSE + 1);
   localparam int SET_W  = (SETTLE_TICKS > 0) ? $clog2(SETTLE_TICKS + 1) : 1;
   localparam logic [2:0] IDX_MASK = 3'(phase_len(HALF_STEP) - 1);

   state_e            state_q, state_d;
   logic [2:0]        idx_q, idx_d, idx_step;
   logic              dir_q, dir_d;
   logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
   logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
   logic [3:0]        coil_q, coil_d;
   logic              tick;

   edge_sync u_edge_sync (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .async_in   (step_clk_in),
      .rise_pulse (tick)
   );

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         dir_q        <= 1'b0;
         step_cnt_q   <= '0;
         settle_cnt_q <= '0;
         coil_q       <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         dir_q        <= dir_d;
         step_cnt_q   <= step_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         coil_q       <= coil_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      dir_d        = dir_q;
      step_cnt_d   = step_cnt_q;
      settle_cnt_d = settle_cnt_q;
      idx_step     = (dir_q ? idx_q + 3'd1 : idx_q - 3'd1) & IDX_MASK;

      case (state_q)
         IDLE: begin
            if (dispense_req && !abort) begin
               state_d    = RUN;
               dir_d      = dir;
               step_cnt_d = '0;
            end
         end
         RUN: begin
            // With no settle period the counter parks at full count for one
            // cycle so the final phase is visible before DONE.
            if (abort) begin
               state_d = IDLE;
            end else if (step_cnt_q == STEP_W'(STEPS_PER_DISPENSE)) begin
               state_d    = DONE;
               step_cnt_d = '0;
            end else if (tick) begin
               idx_d = idx_step;
               if (step_cnt_q == STEP_W'(STEPS_PER_DISPENSE - 1) && SETTLE_TICKS != 0) begin
                  step_cnt_d   = '0;
                  settle_cnt_d = '0;
                  state_d      = SETTLE;
               end else begin
                  step_cnt_d = step_cnt_q + STEP_W'(1);
               end
            end
         end
         SETTLE: begin
            if (abort) begin
               state_d = IDLE;
            end else if (tick) begin
               if (settle_cnt_q == SET_W'(SETTLE_TICKS - 1)) begin
                  state_d      = DONE;
                  settle_cnt_d = '0;
               end else begin
                  settle_cnt_d = settle_cnt_q + SET_W'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      coil_d = 4'b0000;
      if (state_d == RUN || state_d == SETTLE) begin
         coil_d = HALF_STEP ? HALF_TABLE[idx_d] : FULL_TABLE[idx_d[1:0]];
      end
   end

   assign busy = (state_q == RUN) || (state_q == SETTLE);
   assign done = (state_q == DONE);
   assign coil = coil_q;

endmodule

// File: tb/tb_dispense_stepper.sv
// tb/tb_dispense_stepper.sv - directed bench for dispense_stepper, half-step and full-step builds side by side
module tb_dispense_stepper;

   logic             clk_in = 1'b0;
   logic             rst_n = 1'b0;
   logic             step_clk = 1'b0;
   logic [1:0]       req = '0;
   logic [1:0]       dir_s = '0;
   logic [1:0]       abort_s = '0;
   logic [1:0]       busy_w;
   logic [1:0]       done_w;
   logic [1:0][3:0]  coil_w;

   int total = 0;
   int bad = 0;

   logic [3:0] ht [0:7] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};
   logic [3:0] ft [0:3] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
   int m_len [2] = '{8, 4};
   int m_set [2] = '{2, 0};
   localparam int STEPS = 4;

   int         m_phase [2];
   int         m_steps [2];
   int         m_settles [2];
   bit         m_busy [2];
   bit         m_done [2];
   bit         m_dir [2];
   logic [3:0] m_coil [2];
   bit         smp [4];
   int         done_cnt [2] = '{0, 0};
   int         start_cnt [2] = '{0, 0};
   bit         busy_prev [2] = '{0, 0};

   dispense_stepper #(.STEPS_PER_DISPENSE(4), .SETTLE_TICKS(2), .HALF_STEP(1'b1)) dut_a (
      .clk_in(clk_in), .rst_n(rst_n), .step_clk_in(step_clk),
      .dispense_req(req[0]), .dir(dir_s[0]), .abort(abort_s[0]),
      .busy(busy_w[0]), .done(done_w[0]), .coil(coil_w[0])
   );

   dispense_stepper #(.STEPS_PER_DISPENSE(4), .SETTLE_TICKS(0), .HALF_STEP(1'b0)) dut_b (
      .clk_in(clk_in), .rst_n(rst_n), .step_clk_in(step_clk),
      .dispense_req(req[1]), .dir(dir_s[1]), .abort(abort_s[1]),
      .busy(busy_w[1]), .done(done_w[1]), .coil(coil_w[1])
   );

   initial forever #5 clk_in = ~clk_in;
   initial begin
      #3;
      forever #200 step_clk = ~step_clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Behavioural model: a dispense is "steps still owed", then "settle ticks owed", then one done cycle.
   task automatic model_step(input int i, input bit tk);
      if (m_done[i]) begin
         m_done[i] = 1'b0;
      end else if (!m_busy[i]) begin
         if (req[i] && !abort_s[i]) begin
            m_busy[i] = 1'b1; m_dir[i] = dir_s[i]; m_steps[i] = 0; m_settles[i] = 0;
         end
      end else if (abort_s[i]) begin
         m_busy[i] = 1'b0;
      end else if (m_steps[i] < STEPS) begin
         if (tk) begin
            m_phase[i] = (m_phase[i] + (m_dir[i] ? 1 : m_len[i] - 1)) % m_len[i];
            m_steps[i]++;
         end
      end else if (m_set[i] == 0) begin
         m_busy[i] = 1'b0; m_done[i] = 1'b1;
      end else if (tk) begin
         m_settles[i]++;
         if (m_settles[i] == m_set[i]) begin
            m_busy[i] = 1'b0; m_done[i] = 1'b1;
         end
      end
      m_coil[i] = !m_busy[i] ? 4'b0000 : (m_len[i] == 8 ? ht[m_phase[i]] : ft[m_phase[i] % 4]);
   endtask

   always @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0; m_steps[i] = 0; m_settles[i] = 0;
            m_busy[i] = 0; m_done[i] = 0; m_dir[i] = 0; m_coil[i] = 4'b0000;
         end
         for (int k = 0; k < 4; k++) smp[k] = 1'b0;
      end else begin
         smp[3] = smp[2]; smp[2] = smp[1]; smp[1] = smp[0]; smp[0] = step_clk;
         for (int i = 0; i < 2; i++) model_step(i, smp[2] & ~smp[3]);
      end
   end

   always @(negedge clk_in) begin
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("model_coil%0d", i), 32'(coil_w[i]), 32'(m_coil[i]));
         chk($sformatf("model_busy%0d", i), 32'(busy_w[i]), 32'(m_busy[i]));
         chk($sformatf("model_done%0d", i), 32'(done_w[i]), 32'(m_done[i]));
         if (done_w[i] === 1'b1) done_cnt[i]++;
         if (busy_w[i] === 1'b1 && !busy_prev[i]) start_cnt[i]++;
         busy_prev[i] = (busy_w[i] === 1'b1);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk_in);
      #2;
   endtask

   task automatic start(input int i, input bit d);
      cyc(1);
      req[i] = 1'b1; dir_s[i] = d;
      cyc(1);
      req[i] = 1'b0;
      @(negedge clk_in);
   endtask

   task automatic wait_change(input int i, output logic [3:0] v);
      logic [3:0] prev;
      int n;
      prev = coil_w[i];
      n = 0;
      do begin
         @(negedge clk_in);
         n++;
      end while (coil_w[i] === prev && n < 300);
      v = coil_w[i];
      if (coil_w[i] === prev) begin
         total++; bad++;
         $display("FAIL coil_change_timeout%0d: got %0h want a new phase", i, v);
      end
   endtask

   task automatic wait_done(input int i);
      int n;
      n = 0;
      do begin
         @(negedge clk_in);
         n++;
      end while (done_w[i] !== 1'b1 && n < 600);
      if (done_w[i] !== 1'b1) begin
         total++; bad++;
         $display("FAIL done_timeout%0d: got 0 want 1", i);
      end
   endtask

   task automatic run_seq(input int i, input string nm, input logic [3:0] s0, input logic [3:0] s1,
                          input logic [3:0] s2, input logic [3:0] s3);
      logic [3:0] v;
      wait_change(i, v); chk({nm, "_p1"}, 32'(v), 32'(s0));
      wait_change(i, v); chk({nm, "_p2"}, 32'(v), 32'(s1));
      wait_change(i, v); chk({nm, "_p3"}, 32'(v), 32'(s2));
      wait_change(i, v); chk({nm, "_p4"}, 32'(v), 32'(s3));
   endtask

   task automatic check_done_cycle(input int i, input string nm);
      chk({nm, "_done_coil"}, 32'(coil_w[i]), 32'h0);
      chk({nm, "_done_busy"}, 32'(busy_w[i]), 32'h0);
      @(negedge clk_in);
      chk({nm, "_done_one_cycle"}, 32'(done_w[i]), 32'h0);
   endtask

   initial begin
      logic [3:0] v;
      int d0, s0;
      #12;
      chk("reset_coil", 32'(coil_w[0]), 32'h0);
      chk("reset_busy", 32'(busy_w[0]), 32'h0);
      chk("reset_done", 32'(done_w[0]), 32'h0);
      cyc(2);
      rst_n = 1'b1;
      cyc(3);

      // 1: forward half-step dispense with settle
      start(0, 1'b1);
      chk("t1_busy", 32'(busy_w[0]), 32'h1);
      chk("t1_coil0", 32'(coil_w[0]), 32'h8);
      run_seq(0, "t1", 4'b1100, 4'b0100, 4'b0110, 4'b0010);
      wait_done(0);
      check_done_cycle(0, "t1");

      // 2: reverse from the persisted index
      start(0, 1'b0);
      chk("t2_coil0", 32'(coil_w[0]), 32'h2);
      run_seq(0, "t2", 4'b0110, 4'b0100, 4'b1100, 4'b1000);
      wait_done(0);
      check_done_cycle(0, "t2");
      cyc(1);
      chk("t2_done_count", 32'(done_cnt[0]), 32'd2);

      // 3: abort after the second step
      start(0, 1'b1);
      wait_change(0, v);
      wait_change(0, v);
      chk("t3_phase_before_abort", 32'(v), 32'h4);
      cyc(1);
      abort_s[0] = 1'b1;
      cyc(1);
      abort_s[0] = 1'b0;
      @(negedge clk_in);
      chk("t3_abort_coil", 32'(coil_w[0]), 32'h0);
      chk("t3_abort_busy", 32'(busy_w[0]), 32'h0);
      cyc(2);
      chk("t3_no_done", 32'(done_cnt[0]), 32'd2);
      start(0, 1'b1);
      chk("t3_restart_coil", 32'(coil_w[0]), 32'h4);
      wait_done(0);
      cyc(1);
      chk("t3_done_count", 32'(done_cnt[0]), 32'd3);

      // 4: request held high, back-to-back dispenses
      d0 = done_cnt[0];
      s0 = start_cnt[0];
      req[0] = 1'b1; dir_s[0] = 1'b1;
      wait_done(0);
      wait_done(0);
      wait_done(0);
      cyc(1);
      req[0] = 1'b0;
      cyc(4);
      chk("t4_done_pulses", 32'(done_cnt[0] - d0), 32'd3);
      chk("t4_starts", 32'(start_cnt[0] - s0), 32'd3);
      chk("t4_idle_after", 32'(busy_w[0]), 32'h0);

      // 5: asynchronous reset mid-run
      start(0, 1'b1);
      wait_change(0, v);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_coil", 32'(coil_w[0]), 32'h0);
      chk("t5_rst_busy", 32'(busy_w[0]), 32'h0);
      chk("t5_rst_done", 32'(done_w[0]), 32'h0);
      cyc(3);
      rst_n = 1'b1;
      cyc(2);
      start(0, 1'b1);
      chk("t5_restart_coil", 32'(coil_w[0]), 32'h8);
      wait_done(0);

      // 6: full-step build with no settle period
      cyc(2);
      chk("t6_b_idle_before", 32'(done_cnt[1]), 32'd0);
      start(1, 1'b1);
      chk("t6_coil0", 32'(coil_w[1]), 32'hC);
      chk("t6_busy", 32'(busy_w[1]), 32'h1);
      run_seq(1, "t6", 4'b0110, 4'b0011, 4'b1001, 4'b1100);
      @(negedge clk_in);
      chk("t6_done_next", 32'(done_w[1]), 32'h1);
      check_done_cycle(1, "t6");
      cyc(1);
      chk("t6_done_count", 32'(done_cnt[1]), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      bad++;
      $display("FAIL watchdog: got timeout want completion");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
